// File: rtl/axi_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_mem_responder_if                                          |
// | Purpose  : AXI4 bundle for the 512-bit controller-side port (AW/W/B/AR/R) |
// | Modports : slave  - memory responder side (drives readies, B and R)      |
// |            master - traffic generator side (drives AW, W, AR, bready,    |
// |                     rready)                                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface axi_mem_responder_if;
  // Write address channel
  logic [5:0]   awid;
  logic [32:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  // Write data channel
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  // Write response channel
  logic [5:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  // Read address channel
  logic [5:0]   arid;
  logic [32:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  // Read data channel
  logic [5:0]   rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_mem_responder                                             |
// | Purpose  : AXI4 slave memory model on the 512-bit port. Accepts INCR     |
// |            write bursts into a beat-addressed RAM and returns read       |
// |            bursts from it, with optional LFSR backpressure.              |
// | Ports    : axi_clk     - clock                                           |
// |            rstn        - asynchronous active-low reset                   |
// |            throttle_en - enables pseudo-random backpressure              |
// |            bus         - AXI4 slave modport (AW/W/B/AR/R)                |
// |            proto_err   - sticky, set on a wlast/beat-count mismatch      |
// |            wr_beats    - accepted W beats (wraps)                        |
// |            rd_beats    - accepted R beats (wraps)                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_mem_responder #(
  parameter int         MEM_AW    = 10,
  parameter int         ASIZE     = 6,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 axi_clk,
  input  logic                 rstn,
  input  logic                 throttle_en,
  axi_mem_responder_if.slave   bus,
  output logic                 proto_err,
  output logic [31:0]          wr_beats,
  output logic [31:0]          rd_beats
);

  localparam int                c_depth   = 1 << MEM_AW;
  localparam logic [2:0]        c_asize   = 3'(ASIZE);
  localparam logic [MEM_AW-1:0] c_idx_one = MEM_AW'(1);
  localparam logic [1:0]        c_slverr  = 2'b10;
  localparam logic [1:0]        c_okay    = 2'b00;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

  // Beat-addressed storage; never reset so contents survive rstn.
  logic [511:0] mem_q [c_depth];

  // Throttle LFSR (Fibonacci, taps 8,6,5,4)
  logic [7:0] lfsr_q, lfsr_d;
  logic       stall_next;

  // Write side
  w_state_e          w_state_q, w_state_d;
  logic [5:0]        w_id_q, w_id_d;
  logic [MEM_AW-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [5:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              proto_err_q, proto_err_d;
  logic [31:0]       wr_beats_q, wr_beats_d;
  logic              mem_we;
  logic              w_beat_last;

  // Read side
  r_state_e          r_state_q, r_state_d;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic              r_err_q, r_err_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [5:0]        rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [511:0]      rdata_q;
  logic [31:0]       rd_beats_q, rd_beats_d;
  logic              rd_load;
  logic [MEM_AW-1:0] rd_idx;

  // Burst type and the bits outside the beat index are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.awburst, bus.arburst,
                         bus.awaddr[32:MEM_AW+6], bus.awaddr[5:0],
                         bus.araddr[32:MEM_AW+6], bus.araddr[5:0]};

  // Readies/valids are registered, so they are decided from the stall value
  // the LFSR will present in the following cycle.
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall_next = throttle_en & lfsr_d[0];

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    proto_err_d = proto_err_q;
    wr_beats_d  = wr_beats_q;
    mem_we      = 1'b0;
    w_beat_last = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          w_id_d    = bus.awid;
          w_idx_d   = bus.awaddr[MEM_AW+5:6];
          w_len_d   = bus.awlen;
          w_cnt_d   = 8'd0;
          w_err_d   = (bus.awsize != c_asize);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid && wready_q) begin
          w_beat_last = (w_cnt_q == w_len_q);
          // Error state from before this beat gates the write; a wlast
          // mismatch on this beat only suppresses the following beats.
          mem_we     = !w_err_q;
          w_idx_d    = w_idx_q + c_idx_one;
          w_cnt_d    = w_cnt_q + 8'd1;
          wr_beats_d = wr_beats_q + 32'd1;
          if (bus.wlast != w_beat_last) begin
            proto_err_d = 1'b1;
            w_err_d     = 1'b1;
          end
          // Beat count, not wlast, terminates the burst.
          if (w_beat_last) begin
            bid_d     = w_id_q;
            bresp_d   = w_err_d ? c_slverr : c_okay;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bus.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA) && !stall_next;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q      <= LFSR_SEED;
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_err_q     <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      proto_err_q <= 1'b0;
      wr_beats_q  <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_err_q     <= w_err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      proto_err_q <= proto_err_d;
      wr_beats_q  <= wr_beats_d;
    end
  end

  // Byte-masked RAM write. Reads below sample the pre-edge contents, so a
  // same-cycle fetch of the written beat returns old data.
  always_ff @(posedge axi_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 64; b++) begin
        if (bus.wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_err_d    = r_err_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rd_beats_d = rd_beats_q;
    rd_load    = 1'b0;
    rd_idx     = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          rid_d     = bus.arid;
          r_idx_d   = bus.araddr[MEM_AW+5:6];
          r_len_d   = bus.arlen;
          r_cnt_d   = 8'd0;
          r_err_d   = (bus.arsize != c_asize);
          rresp_d   = (bus.arsize != c_asize) ? c_slverr : c_okay;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_load   = 1'b1;
        rlast_d   = (r_cnt_q == r_len_q);
        rvalid_d  = !stall_next;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q) begin
          if (bus.rready) begin
            rd_beats_d = rd_beats_q + 32'd1;
            if (rlast_q) begin
              rvalid_d  = 1'b0;
              rlast_d   = 1'b0;
              r_state_d = R_IDLE;
            end else begin
              // Load the next beat on the handshake edge: no bubble when
              // the master keeps rready high and there is no stall.
              r_idx_d  = r_idx_q + c_idx_one;
              r_cnt_d  = r_cnt_q + 8'd1;
              rd_idx   = r_idx_d;
              rd_load  = 1'b1;
              rlast_d  = (r_cnt_d == r_len_q);
              rvalid_d = !stall_next;
            end
          end
        end else begin
          rvalid_d = !stall_next;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      r_idx_q    <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_err_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rd_beats_q <= '0;
    end else begin
      r_state_q  <= r_state_d;
      r_idx_q    <= r_idx_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      r_err_q    <= r_err_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rd_beats_q <= rd_beats_d;
      if (rd_load) rdata_q <= r_err_q ? '0 : mem_q[rd_idx];
    end
  end

  // ------------------------------------------------------------------ outputs
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign proto_err   = proto_err_q;
  assign wr_beats    = wr_beats_q;
  assign rd_beats    = rd_beats_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_mem_responder                                          |
// | Purpose  : Self-checking bench for axi_mem_responder with a beat-level   |
// |            memory reference model and randomized traffic.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi_mem_responder;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int LIM    = 2000;

  logic        axi_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        throttle_en = 1'b0;
  logic        proto_err;
  logic [31:0] wr_beats, rd_beats;

  axi_mem_responder_if bus();

  axi_mem_responder #(.MEM_AW(MEM_AW), .ASIZE(6), .LFSR_SEED(8'hA5)) dut (
    .axi_clk     (axi_clk),
    .rstn        (rstn),
    .throttle_en (throttle_en),
    .bus         (bus),
    .proto_err   (proto_err),
    .wr_beats    (wr_beats),
    .rd_beats    (rd_beats)
  );

  always #5 axi_clk = ~axi_clk;

  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [511:0] ref_mem [DEPTH];
  logic         exp_proto = 1'b0;
  int unsigned  exp_wr = 0;
  int unsigned  exp_rd = 0;
  logic [511:0] wd [256];
  logic [63:0]  ws [256];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    $error("FAIL %s: timed out after %0d cycles", tag, LIM);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Write burst of beats wd/ws[0..len]; wlast is driven on beat wl_at.
  task automatic axi_write(input logic [32:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [5:0] id, input int wl_at);
    logic       err;
    int         idx, t;
    logic [1:0] exp_bresp;
    err = (size != 3'd6);
    idx = int'(addr[MEM_AW+5:6]);
    for (int k = 0; k <= int'(len); k++) begin
      if (!err)
        for (int b = 0; b < 64; b++)
          if (ws[k][b]) ref_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
      if ((k == wl_at) != (k == int'(len))) begin
        err = 1'b1;
        exp_proto = 1'b1;
      end
      idx = (idx + 1) % DEPTH;
    end
    exp_bresp = err ? 2'b10 : 2'b00;
    exp_wr += int'(len) + 1;

    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIM) begin @(negedge axi_clk); t++; end
    if (t >= LIM) timeout_fail("aw_handshake");
    @(negedge axi_clk);
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = (k == wl_at); bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < LIM) begin @(negedge axi_clk); t++; end
      if (t >= LIM) timeout_fail("w_handshake");
      @(negedge axi_clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < LIM) begin @(negedge axi_clk); t++; end
    if (t >= LIM) timeout_fail("b_handshake");
    chk("bresp", 512'(bus.bresp), 512'(exp_bresp));
    chk("bid", 512'(bus.bid), 512'(id));
    @(negedge axi_clk);
    bus.bready = 1'b0;
    chk("wr_beats", 512'(wr_beats), 512'(exp_wr));
    chk("proto_err", 512'(proto_err), 512'(exp_proto));
  endtask

  // Read burst; rmode 0 = rready high, 1 = toggling, 2 = random.
  // Stops early (without finishing the burst) after abort_after beats.
  task automatic axi_read(input logic [32:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [5:0] id,
                          input int rmode, input int abort_after);
    logic err, first_seen, prev_hold;
    int   idx, k, t, hs_cyc;
    err = (size != 3'd6);
    idx = int'(addr[MEM_AW+5:6]);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIM) begin @(negedge axi_clk); t++; end
    if (t >= LIM) timeout_fail("ar_handshake");
    hs_cyc = cyc;
    @(negedge axi_clk);
    bus.arvalid = 1'b0;
    k = 0; t = 0; first_seen = 1'b0; prev_hold = 1'b0; bus.rready = 1'b0;
    while (k <= int'(len) && k < abort_after && t < LIM) begin
      case (rmode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = ~bus.rready;
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      if (prev_hold) chk("rvalid_held", 512'(bus.rvalid), 512'(1'b1));
      if (bus.rvalid && !first_seen) begin
        first_seen = 1'b1;
        if (!throttle_en) chk("r_latency", 512'(cyc - hs_cyc), 512'(2));
      end
      if (bus.rvalid && bus.rready) begin
        chk("rdata", bus.rdata, err ? 512'd0 : ref_mem[(idx + k) % DEPTH]);
        chk("rlast", 512'(bus.rlast), 512'(k == int'(len)));
        chk("rresp", 512'(bus.rresp), 512'(err ? 2'b10 : 2'b00));
        chk("rid", 512'(bus.rid), 512'(id));
        k++;
        exp_rd++;
      end
      prev_hold = bus.rvalid && !bus.rready;
      @(negedge axi_clk);
      t++;
    end
    bus.rready = 1'b0;
    if (t >= LIM) timeout_fail("r_burst");
    if (k > int'(len)) begin
      chk("rd_beats", 512'(rd_beats), 512'(exp_rd));
      chk("rvalid_after_last", 512'(bus.rvalid), 512'(1'b0));
    end
  endtask

  initial begin
    logic [32:0] addr;
    logic [7:0]  len;
    int          idx;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge axi_clk);
    chk("rst_awready", 512'(bus.awready), 512'(1'b0));
    chk("rst_arready", 512'(bus.arready), 512'(1'b0));
    chk("rst_wready", 512'(bus.wready), 512'(1'b0));
    chk("rst_bvalid", 512'(bus.bvalid), 512'(1'b0));
    chk("rst_rvalid", 512'(bus.rvalid), 512'(1'b0));
    chk("rst_rdata", bus.rdata, 512'd0);
    chk("rst_proto_err", 512'(proto_err), 512'(1'b0));
    chk("rst_wr_beats", 512'(wr_beats), 512'd0);
    rstn = 1'b1;
    repeat (2) @(negedge axi_clk);

    // 64-beat write of beat numbers, then readback
    for (int k = 0; k < 64; k++) begin wd[k] = 512'(k); ws[k] = '1; end
    axi_write(33'h0, 8'd63, 3'd6, 6'h11, 63);
    axi_read(33'h0, 8'd63, 3'd6, 6'h22, 0, 1000);

    // Partial strobe over a full 0xFF beat
    wd[0] = '1; ws[0] = '1;
    axi_write(33'h0, 8'd0, 3'd6, 6'h03, 0);
    wd[0] = '0; ws[0] = 64'h0000_0000_0000_000F;
    axi_write(33'h0, 8'd0, 3'd6, 6'h04, 0);
    axi_read(33'h0, 8'd0, 3'd6, 6'h05, 0, 1000);

    // Index wrap at the top of the RAM
    for (int k = 0; k < 4; k++) begin wd[k] = rand512(); ws[k] = '1; end
    axi_write(33'((DEPTH - 2) * 64), 8'd3, 3'd6, 6'h07, 3);
    axi_read(33'h0, 8'd0, 3'd6, 6'h08, 0, 1000);
    axi_read(33'((DEPTH - 2) * 64 + 6'h25), 8'd3, 3'd6, 6'h09, 0, 1000);

    // Early wlast: all 8 beats accepted, sticky proto_err, SLVERR
    for (int k = 0; k < 8; k++) begin wd[k] = rand512(); ws[k] = '1; end
    axi_write(33'(100 * 64), 8'd7, 3'd6, 6'h0A, 2);
    axi_read(33'(100 * 64), 8'd7, 3'd6, 6'h0B, 0, 1000);

    // Unsupported size: zero data with SLVERR, write leaves RAM alone
    axi_read(33'h0, 8'd1, 3'd5, 6'h0C, 0, 1000);
    for (int k = 0; k < 2; k++) begin wd[k] = rand512(); ws[k] = '1; end
    axi_write(33'h0, 8'd1, 3'd5, 6'h0D, 1);
    axi_read(33'h0, 8'd1, 3'd6, 6'h0E, 0, 1000);

    // Randomized bursts, random throttle/rready, random ignored address bits
    for (int it = 0; it < 8; it++) begin
      throttle_en = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, DEPTH - 1);
      len  = 8'($urandom_range(0, 15));
      addr = {17'($urandom()), 10'(idx), 6'($urandom())};
      for (int k = 0; k <= int'(len); k++) begin wd[k] = rand512(); ws[k] = '1; end
      axi_write(addr, len, 3'd6, 6'($urandom()), int'(len));
      for (int k = 0; k <= int'(len); k++) begin
        wd[k] = rand512(); ws[k] = {$urandom(), $urandom()};
      end
      axi_write({17'($urandom()), 10'(idx), 6'($urandom())}, len, 3'd6, 6'($urandom()), int'(len));
      axi_read({17'($urandom()), 10'(idx), 6'($urandom())}, len, 3'd6, 6'($urandom()), 2, 1000);
    end

    // Throttled 64-beat read with toggling rready
    throttle_en = 1'b1;
    axi_read(33'h0, 8'd63, 3'd6, 6'h2A, 1, 1000);

    // Reset in the middle of a throttled read burst
    axi_read(33'h0, 8'd63, 3'd6, 6'h2B, 1, 20);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 512'(bus.rvalid), 512'(1'b0));
    chk("mid_rst_rlast", 512'(bus.rlast), 512'(1'b0));
    chk("mid_rst_arready", 512'(bus.arready), 512'(1'b0));
    chk("mid_rst_awready", 512'(bus.awready), 512'(1'b0));
    chk("mid_rst_wready", 512'(bus.wready), 512'(1'b0));
    chk("mid_rst_bvalid", 512'(bus.bvalid), 512'(1'b0));
    chk("mid_rst_proto_err", 512'(proto_err), 512'(1'b0));
    chk("mid_rst_rd_beats", 512'(rd_beats), 512'd0);
    chk("mid_rst_wr_beats", 512'(wr_beats), 512'd0);
    exp_rd = 0; exp_wr = 0; exp_proto = 1'b0;
    @(negedge axi_clk);
    rstn = 1'b1;
    throttle_en = 1'b0;
    repeat (2) @(negedge axi_clk);
    axi_read(33'h0, 8'd63, 3'd6, 6'h2C, 0, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Synthesizable AXI4 slave memory model on the 512-bit controller-side AXI port.
- Gives the LFSR memory checker and other AXI traffic generators a closed-loop target for simulation, and for on-chip bring-up without LPDDR4.
- Accepts INCR write bursts into an internal beat-addressed RAM and returns read bursts from it.
- Optional pseudo-random backpressure on wready and on the start of R beats.

Parameters:
MEM_AW, 10, log2 of RAM depth in 64-byte beats (default 1024 beats = 64 KiB)
ASIZE, 6, only supported awsize/arsize; 64-byte beats
LFSR_SEED, 8'hA5, reset value of the 8-bit throttle LFSR (must be non-zero)

Ports:
axi_clk  in  1  clock
rstn  in  1  asynchronous active-low reset
throttle_en  in  1  enables LFSR backpressure
awid  in  6  write ID
awaddr  in  33  write byte address
awlen  in  8  beats-1
awsize  in  3  beat size
awburst  in  2  burst type (treated as INCR)
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  512  write data
wstrb  in  64  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  6  response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  6  read ID
araddr  in  33  read byte address
arlen  in  8  beats-1
arsize  in  3  beat size
arburst  in  2  burst type (treated as INCR)
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  6  read ID
rdata  out  512  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
proto_err  out  1  sticky: wlast mismatch seen
wr_beats  out  32  count of accepted W beats, wraps
rd_beats  out  32  count of accepted R beats, wraps

Behaviour:
- Reset (rstn low, asynchronous):
  - awready, wready, bvalid, arready, rvalid, rlast, proto_err = 0.
  - bid, rid, bresp, rresp = 0; rdata = 0; wr_beats, rd_beats = 0; LFSR = LFSR_SEED.
  - Both FSMs go to IDLE. RAM contents are not reset and are retained across reset.
  - Reset mid-burst abandons the burst; beats already written stay in RAM.
- Beat index:
  - idx = addr[MEM_AW+5:6]; upper address bits and addr[5:0] are ignored.
  - idx increments by 1 per beat, mod 2^MEM_AW.
- Throttle LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every cycle.
  - stall = throttle_en & lfsr[0]. When throttle_en=0, stall = 0.
- Write FSM, one outstanding burst:
  - W_IDLE: awready=1. On awvalid&awready, capture id, idx, len, err=(awsize!=ASIZE); cnt=0; go to W_DATA.
  - W_DATA: wready = ~stall (registered, decided from next-cycle stall).
    - On wvalid&wready: if !err, write each byte of RAM[idx] whose wstrb bit is set.
    - idx++, cnt++, wr_beats++.
    - If wlast != (cnt==len), set proto_err and err.
    - When cnt==len, the burst ends regardless of wlast; go to W_RESP.
  - W_RESP: bvalid=1, bid=captured id, bresp = err ? 2'b10 : 2'b00. On bready go to W_IDLE; awready reasserts the next cycle.
  - awready is 0 outside W_IDLE.
- Read FSM, one outstanding burst, independent of the write FSM:
  - R_IDLE: arready=1. On arvalid&arready, capture id, idx, len, err=(arsize!=ASIZE); go to R_FETCH.
  - R_FETCH: one cycle; registers rdata = err ? 0 : RAM[idx]. Next state R_DATA.
  - R_DATA:
    - rvalid rises only in a cycle with ~stall.
    - Once high, rvalid, rdata, rlast, rresp hold until rready; throttle never drops an asserted rvalid.
    - rlast = (cnt==len); rresp = err ? 2'b10 : 2'b00.
    - On rvalid&rready: rd_beats++. If last, go to R_IDLE. Otherwise idx++ and the next beat is loaded the same cycle, so there are no bubbles with rready=1, stall=0.
  - Latency: AR handshake at cycle N gives first rvalid at N+2 (unthrottled).
- Collisions:
  - Same-cycle read fetch and write to the same idx: read returns old data (read-first).
  - An AR may be accepted while a write burst is in progress; no ordering between channels is enforced.

Test Plan:
- awaddr=0x0, awlen=63, wdata=beat number, wstrb all ones, throttle off; then AR same address -> bresp=0 after 64 W beats; 64 R beats with rdata=0..63, rlast only on beat 63, first rvalid 2 cycles after AR, wr_beats=rd_beats=64.
- Write beat 0 full 0xFF..FF, then write same address with wstrb=64'h0000_0000_0000_000F and data 0 -> read shows bytes 0-3 = 0x00, bytes 4-63 = 0xFF.
- awaddr=(2^MEM_AW-2)*64, awlen=3 -> beats land at idx 1022, 1023, 0, 1; readback at address 0 returns beat 2.
- wlast asserted on beat 2 of awlen=7 -> 8 beats still accepted, proto_err=1 (sticky), bresp=2'b10.
- arsize=5, arlen=1 -> 2 beats, rdata=0, rresp=2'b10; awsize=5 write leaves RAM unchanged.
- throttle_en=1, rready toggling every cycle, 64-beat read -> rvalid never falls without handshake, data matches unthrottled run; assert rstn low mid-burst -> all valids/readies 0 immediately, RAM contents intact afterward.
